// File: rtl/lut_arbiter.sv
// lut_arbiter: two-requester round-robin arbiter in front of one shared,
// single-outstanding LUT port. A granted request is captured, issued to the
// LUT, and its result is buffered and returned to the owning requester.
module lut_arbiter #(
  parameter int NEURON_NUM    = 6,
  parameter int LUT_ADDR_SIZE = 10,
  parameter int LUT_WIDTH     = 9
) (
  input  logic                            clk,
  input  logic                            rst,
  // requester A
  input  logic [NEURON_NUM*LUT_ADDR_SIZE-1:0] a_inputs,
  input  logic                            a_inputs_valid,
  output logic                            a_inputs_ready,
  output logic [NEURON_NUM*LUT_WIDTH-1:0] a_outputs,
  output logic                            a_outputs_valid,
  input  logic                            a_outputs_ready,
  // requester B
  input  logic [NEURON_NUM*LUT_ADDR_SIZE-1:0] b_inputs,
  input  logic                            b_inputs_valid,
  output logic                            b_inputs_ready,
  output logic [NEURON_NUM*LUT_WIDTH-1:0] b_outputs,
  output logic                            b_outputs_valid,
  input  logic                            b_outputs_ready,
  // shared lut
  output logic [NEURON_NUM*LUT_ADDR_SIZE-1:0] lut_inputs,
  output logic                            lut_inputs_valid,
  input  logic                            lut_inputs_ready,
  input  logic [NEURON_NUM*LUT_WIDTH-1:0] lut_outputs,
  input  logic                            lut_outputs_valid,
  output logic                            lut_outputs_ready,
  // status
  output logic                            busy,
  output logic [15:0]                     a_count,
  output logic [15:0]                     b_count
);

  localparam int ADDR_BITS = NEURON_NUM * LUT_ADDR_SIZE;
  localparam int RES_BITS  = NEURON_NUM * LUT_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;
  typedef enum logic {OWN_A, OWN_B} owner_t;

  state_t               r_state;
  state_t               w_state_next;
  owner_t               r_owner;
  owner_t               r_last_owner;
  logic [ADDR_BITS-1:0] r_addr;
  logic [RES_BITS-1:0]  r_res;
  logic [15:0]          r_a_count;
  logic [15:0]          r_b_count;

  logic w_grant_a;
  logic w_grant_b;
  logic w_accept;
  logic w_owner_done;

  // Round-robin: a lone requester wins; on a tie the one not served last wins.
  assign w_grant_a = a_inputs_valid && (!b_inputs_valid || (r_last_owner == OWN_B));
  assign w_grant_b = b_inputs_valid && (!a_inputs_valid || (r_last_owner == OWN_A));
  assign w_accept  = (r_state == IDLE) && (w_grant_a || w_grant_b);

  assign w_owner_done = (r_state == DELIVER) &&
                        ((r_owner == OWN_A) ? a_outputs_ready : b_outputs_ready);

  // Result buses and lut address come straight from registers, so there is
  // no combinational path from the lut result port to either requester.
  assign a_outputs  = r_res;
  assign b_outputs  = r_res;
  assign lut_inputs = r_addr;
  assign busy       = (r_state != IDLE);
  assign a_count    = r_a_count;
  assign b_count    = r_b_count;

  // Next-state and handshake decode for the single-transaction FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_next      = r_state;
    a_inputs_ready    = 1'b0;
    b_inputs_ready    = 1'b0;
    lut_inputs_valid  = 1'b0;
    lut_outputs_ready = 1'b0;
    a_outputs_valid   = 1'b0;
    b_outputs_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        a_inputs_ready = w_grant_a;
        b_inputs_ready = w_grant_b;
        if (w_grant_a || w_grant_b) w_state_next = ISSUE;
      end
      ISSUE: begin
        lut_inputs_valid = 1'b1;
        if (lut_inputs_ready) w_state_next = WAIT;
      end
      WAIT: begin
        lut_outputs_ready = 1'b1;
        if (lut_outputs_valid) w_state_next = DELIVER;
      end
      DELIVER: begin
        a_outputs_valid = (r_owner == OWN_A);
        b_outputs_valid = (r_owner == OWN_B);
        if (w_owner_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register, captured address/result, ownership and completion counts.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here, so every register samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= OWN_A;
      r_last_owner <= OWN_B;
      r_addr       <= '0;
      r_res        <= '0;
      r_a_count    <= '0;
      r_b_count    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_owner <= w_grant_a ? OWN_A : OWN_B;
        r_addr  <= w_grant_a ? a_inputs : b_inputs;
      end
      if ((r_state == WAIT) && lut_outputs_valid) begin
        r_res <= lut_outputs;
      end
      if (w_owner_done) begin
        r_last_owner <= r_owner;
        if (r_owner == OWN_A) r_a_count <= r_a_count + 16'd1;
        else                  r_b_count <= r_b_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lut_arbiter.sv
// Testbench for lut_arbiter: lut stub (result = address/2 per lane, two extra
// cycles of latency), scoreboard monitor fed on every accepted request, and
// directed plus randomized requester traffic.
module tb_lut_arbiter;

  localparam int N  = 6;
  localparam int AW = 10;
  localparam int LW = 9;
  localparam int BUDGET = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*AW-1:0] a_inputs = '0, b_inputs = '0;
  logic            a_inputs_valid = 1'b0, b_inputs_valid = 1'b0;
  logic            a_inputs_ready, b_inputs_ready;
  logic [N*LW-1:0] a_outputs, b_outputs;
  logic            a_outputs_valid, b_outputs_valid;
  logic            a_outputs_ready = 1'b1, b_outputs_ready = 1'b1;
  logic [N*AW-1:0] lut_inputs;
  logic            lut_inputs_valid, lut_inputs_ready;
  logic [N*LW-1:0] lut_outputs;
  logic            lut_outputs_valid, lut_outputs_ready;
  logic            busy;
  logic [15:0]     a_count, b_count;

  lut_arbiter #(.NEURON_NUM(N), .LUT_ADDR_SIZE(AW), .LUT_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .a_inputs(a_inputs), .a_inputs_valid(a_inputs_valid), .a_inputs_ready(a_inputs_ready),
    .a_outputs(a_outputs), .a_outputs_valid(a_outputs_valid), .a_outputs_ready(a_outputs_ready),
    .b_inputs(b_inputs), .b_inputs_valid(b_inputs_valid), .b_inputs_ready(b_inputs_ready),
    .b_outputs(b_outputs), .b_outputs_valid(b_outputs_valid), .b_outputs_ready(b_outputs_ready),
    .lut_inputs(lut_inputs), .lut_inputs_valid(lut_inputs_valid), .lut_inputs_ready(lut_inputs_ready),
    .lut_outputs(lut_outputs), .lut_outputs_valid(lut_outputs_valid), .lut_outputs_ready(lut_outputs_ready),
    .busy(busy), .a_count(a_count), .b_count(b_count)
  );

  // ---------------- lut stub ----------------
  logic            stub_en = 1'b1;
  logic            spurious = 1'b0;
  logic            stub_pend;
  logic [1:0]      stub_dly;
  logic [N*AW-1:0] stub_addr;

  assign lut_inputs_ready  = stub_en && !stub_pend;
  assign lut_outputs_valid = (stub_pend && (stub_dly == 2'd0)) || spurious;

  always_comb begin
    lut_outputs = '0;
    if (spurious) lut_outputs = '1;
    else for (int i = 0; i < N; i++) lut_outputs[i*LW +: LW] = stub_addr[i*AW+1 +: LW];
  end

  always @(posedge clk) begin
    if (rst) begin
      stub_pend <= 1'b0;
      stub_dly  <= 2'd0;
      stub_addr <= '0;
    end else if (stub_pend) begin
      if (lut_outputs_valid && lut_outputs_ready) stub_pend <= 1'b0;
      else if (stub_dly != 2'd0) stub_dly <= stub_dly - 2'd1;
    end else if (lut_inputs_valid && lut_inputs_ready) begin
      stub_pend <= 1'b1;
      stub_dly  <= 2'd2;
      stub_addr <= lut_inputs;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each lane's result is its address halved.
  function automatic logic [N*LW-1:0] ref_result(input logic [N*AW-1:0] v);
    logic [N*LW-1:0] r;
    int unsigned lane;
    r = '0;
    for (int i = 0; i < N; i++) begin
      lane = int'(v[i*AW +: AW]);
      r[i*LW +: LW] = LW'(lane / 2);
    end
    return r;
  endfunction

  typedef struct {
    bit              own_b;
    logic [N*LW-1:0] res;
  } exp_t;

  exp_t sb_q[$];
  bit   last_b = 1'b1;
  int   exp_a = 0, exp_b = 0;
  bit   ga, gb;
  exp_t e;

  // Monitor: predicts grants, queues expected results on accepts, and checks
  // every delivered result, owner and completion count.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      last_b = 1'b1;
      exp_a  = 0;
      exp_b  = 0;
    end else if (!busy) begin
      if (a_inputs_valid || b_inputs_valid) begin
        ga = a_inputs_valid && (!b_inputs_valid || last_b);
        gb = b_inputs_valid && (!a_inputs_valid || !last_b);
        check("grant", {a_inputs_ready, b_inputs_ready}, {ga, gb});
        if (a_inputs_valid && a_inputs_ready)      sb_q.push_back('{1'b0, ref_result(a_inputs)});
        else if (b_inputs_valid && b_inputs_ready) sb_q.push_back('{1'b1, ref_result(b_inputs)});
      end
      if (lut_outputs_valid) check("lut_ready_outside_wait", lut_outputs_ready, 0);
      if (a_outputs_valid || b_outputs_valid)
        check("out_valid_in_idle", {a_outputs_valid, b_outputs_valid}, 0);
    end else begin
      check("no_accept_when_busy", {a_inputs_ready, b_inputs_ready}, 0);
      if (a_outputs_valid || b_outputs_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", {a_outputs_valid, b_outputs_valid}, 0);
        end else begin
          e = sb_q[0];
          check("owner_valid", {a_outputs_valid, b_outputs_valid}, {!e.own_b, e.own_b});
          check("a_data", a_outputs, e.res);
          check("b_data", b_outputs, e.res);
          check("counts", {a_count, b_count}, {16'(exp_a), 16'(exp_b)});
          if (e.own_b ? b_outputs_ready : a_outputs_ready) begin
            void'(sb_q.pop_front());
            last_b = e.own_b;
            if (e.own_b) exp_b++;
            else         exp_a++;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return a_inputs_valid && a_inputs_ready;
      1:       return b_inputs_valid && b_inputs_ready;
      2:       return a_outputs_valid;
      3:       return b_outputs_valid;
      4:       return !busy;
      default: return lut_outputs_ready;
    endcase
  endfunction

  // Returns at the negedge where the condition holds; counts negedges waited.
  task automatic wait_for(input int sel, input string name, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles > BUDGET) begin
        n_cmp++;
        n_fail++;
        $display("FAIL timeout_%s: no event after %0d cycles", name, BUDGET);
        return;
      end
    end while (!cond(sel));
  endtask

  function automatic logic [N*AW-1:0] rand_vec();
    logic [N*AW-1:0] v;
    for (int i = 0; i < N; i++) v[i*AW +: AW] = AW'($urandom_range(0, 1023));
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [N*LW-1:0] exp_vec, held;
    logic [N*AW-1:0] acc;
    bit a_took, b_took;

    do_reset();
    tick();
    @(negedge clk);
    check("reset_state", {a_outputs_valid, b_outputs_valid, a_inputs_ready, b_inputs_ready,
                          lut_inputs_valid, lut_outputs_ready, busy}, 0);
    check("reset_counts", {a_count, b_count}, 0);
    check("reset_res", a_outputs, 0);

    // A alone: fixed vector, known result, latency 3 + 2 stub cycles.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) a_inputs[i*AW +: AW] = AW'(200 * i);
    a_inputs_valid = 1'b1;
    wait_for(0, "a_accept", cyc);
    @(posedge clk); #1;
    a_inputs_valid = 1'b0;
    wait_for(2, "a_result", cyc);
    check("a_latency", cyc, 5);
    for (int i = 0; i < N; i++) exp_vec[i*LW +: LW] = LW'(100 * i);
    check("a_fixed_result", a_outputs, exp_vec);
    wait_for(4, "idle", cyc);
    check("a_count_one", {a_count, b_count}, {16'd1, 16'd0});

    // A and B together after reset: A, B, A.
    do_reset();
    a_inputs = rand_vec();
    b_inputs = rand_vec();
    a_inputs_valid = 1'b1;
    b_inputs_valid = 1'b1;
    wait_for(2, "rr_a1", cyc);
    @(negedge clk);
    check("rr_counts_1", {a_count, b_count}, {16'd1, 16'd0});
    check("rr_b_granted", {a_inputs_ready, b_inputs_ready}, 2'b01);
    wait_for(3, "rr_b1", cyc);
    @(negedge clk);
    check("rr_counts_2", {a_count, b_count}, {16'd1, 16'd1});
    check("rr_a_granted", {a_inputs_ready, b_inputs_ready}, 2'b10);
    wait_for(2, "rr_a2", cyc);
    a_inputs_valid = 1'b0;
    b_inputs_valid = 1'b0;
    @(negedge clk);
    check("rr_counts_3", {a_count, b_count}, {16'd2, 16'd1});

    // lut not ready for 5 cycles in ISSUE; B waiting must not be accepted.
    wait_for(4, "idle", cyc);
    @(posedge clk); #1;
    stub_en = 1'b0;
    a_inputs = rand_vec();
    a_inputs_valid = 1'b1;
    wait_for(0, "stall_accept", cyc);
    acc = a_inputs;
    @(posedge clk); #1;
    a_inputs_valid = 1'b0;
    b_inputs = rand_vec();
    b_inputs_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("issue_stall_addr", lut_inputs, acc);
      check("issue_stall_valid_ready", {lut_inputs_valid, b_inputs_ready}, 2'b10);
    end
    stub_en = 1'b1;
    wait_for(1, "b_after_stall", cyc);
    @(posedge clk); #1;
    b_inputs_valid = 1'b0;
    wait_for(3, "b_result", cyc);

    // A result held 10 cycles by a_outputs_ready=0 while B is waiting.
    wait_for(4, "idle", cyc);
    @(posedge clk); #1;
    a_outputs_ready = 1'b0;
    a_inputs = rand_vec();
    a_inputs_valid = 1'b1;
    wait_for(0, "hold_accept", cyc);
    @(posedge clk); #1;
    a_inputs_valid = 1'b0;
    wait_for(2, "hold_result", cyc);
    held = a_outputs;
    b_inputs = rand_vec();
    b_inputs_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("deliver_hold_flags", {a_outputs_valid, busy, b_inputs_ready}, 3'b110);
      check("deliver_hold_data", a_outputs, held);
    end
    a_outputs_ready = 1'b1;
    wait_for(1, "b_after_hold", cyc);
    @(posedge clk); #1;
    b_inputs_valid = 1'b0;
    wait_for(3, "b_result2", cyc);
    wait_for(4, "idle", cyc);

    // Spurious lut valid in IDLE: ignored, result buffer untouched.
    held = b_outputs;
    @(posedge clk); #1;
    spurious = 1'b1;
    @(negedge clk);
    check("spurious_lut_ready", lut_outputs_ready, 0);
    @(posedge clk); #1;
    spurious = 1'b0;
    @(negedge clk);
    check("spurious_res_a", a_outputs, held);
    check("spurious_res_b", b_outputs, held);

    // Reset while waiting on the lut; then a clean A request.
    @(posedge clk); #1;
    a_inputs = rand_vec();
    a_inputs_valid = 1'b1;
    wait_for(0, "rst_accept", cyc);
    @(posedge clk); #1;
    a_inputs_valid = 1'b0;
    wait_for(5, "rst_wait_state", cyc);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_flags", {a_outputs_valid, b_outputs_valid, a_inputs_ready, b_inputs_ready,
                           lut_inputs_valid, lut_outputs_ready, busy}, 0);
    check("midrst_counts", {a_count, b_count}, 0);
    check("midrst_data", {a_outputs, lut_inputs}, 0);
    @(posedge clk); #1;
    a_inputs = rand_vec();
    a_inputs_valid = 1'b1;
    wait_for(0, "post_rst_accept", cyc);
    @(posedge clk); #1;
    a_inputs_valid = 1'b0;
    wait_for(2, "post_rst_result", cyc);
    wait_for(4, "idle", cyc);
    check("post_rst_count", {a_count, b_count}, {16'd1, 16'd0});

    // Randomized traffic: random valids (including withdrawals), readies, lut stalls.
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      a_took = a_inputs_valid && a_inputs_ready;
      b_took = b_inputs_valid && b_inputs_ready;
      @(posedge clk); #1;
      if (a_took) a_inputs_valid = 1'b0;
      else if (a_inputs_valid && ($urandom_range(0, 9) == 0)) a_inputs_valid = 1'b0;
      if (!a_inputs_valid && ($urandom_range(0, 2) == 0)) begin
        a_inputs_valid = 1'b1;
        a_inputs = rand_vec();
      end
      if (b_took) b_inputs_valid = 1'b0;
      else if (b_inputs_valid && ($urandom_range(0, 9) == 0)) b_inputs_valid = 1'b0;
      if (!b_inputs_valid && ($urandom_range(0, 2) == 0)) begin
        b_inputs_valid = 1'b1;
        b_inputs = rand_vec();
      end
      a_outputs_ready = ($urandom_range(0, 3) != 0);
      b_outputs_ready = ($urandom_range(0, 3) != 0);
      stub_en         = ($urandom_range(0, 3) != 0);
    end
    a_inputs_valid  = 1'b0;
    b_inputs_valid  = 1'b0;
    a_outputs_ready = 1'b1;
    b_outputs_ready = 1'b1;
    stub_en         = 1'b1;
    wait_for(4, "final_idle", cyc);
    @(negedge clk);
    check("final_counts", {a_count, b_count}, {16'(exp_a), 16'(exp_b)});
    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
